// File: rtl/irq_pkg.sv
// Shared constants and the state encoding for the machine external interrupt controller.
// Contents: cause base for external lines, mie bit offset of line 0, FSM state enum.
// Imported by irq_controller; sits beside csr_pkg in the CSR/trap slice.
package irq_pkg;

    // mcause for external line k is IRQ_CAUSE_BASE + k (interrupt bit set).
    localparam logic [31:0] IRQ_CAUSE_BASE = 32'h8000_0010;

    // Line k is enabled by mie bit IRQ_MIE_OFFSET + k.
    localparam int IRQ_MIE_OFFSET = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY   = 2'd1,
        RETURN = 2'd2
    } irq_state_t;

endpackage

// File: rtl/irq_priority_enc.sv
// Combinational find-first-set: lowest set index of req_i wins.
// Ports: req_i [N-1:0] in; vld_o (any bit set), idx_o [3:0] (index of lowest set bit, 0 if none).
// Zero latency, no state, no backpressure.
module irq_priority_enc #(
    parameter int N = 16
) (
    input  logic [N-1:0] req_i,
    output logic         vld_o,
    output logic [3:0]   idx_o
);

    // Scan from the top down so the lowest set index is the last write.
    always_comb begin
        vld_o = 1'b0;
        idx_o = 4'd0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                vld_o = 1'b1;
                idx_o = 4'(i);
            end
        end
    end

endmodule

// File: rtl/irq_controller.sv
// Machine external interrupt controller: masks level requests with mie, issues one
//   interrupt by fixed priority, blocks further issue until the matching mret, then acks.
// Ports: clk_i, rst_i (sync, active-high); irq_req_i/mie_i/exception_i/mret_i in;
//   irq_o (issue pulse), irq_cause_o (mcause), irq_ret_o (one-hot ack), busy_o out.
module irq_controller
    import irq_pkg::*;
#(
    parameter int N_IRQ   = 16,
    parameter int DEPTH_W = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [N_IRQ-1:0] irq_req_i,
    input  logic [31:0]      mie_i,
    input  logic             exception_i,
    input  logic             mret_i,
    output logic             irq_o,
    output logic [31:0]      irq_cause_o,
    output logic [N_IRQ-1:0] irq_ret_o,
    output logic             busy_o
);

    localparam logic [DEPTH_W-1:0] DEPTH_MAX = '1;

    irq_state_t         state_q, state_d;
    logic [3:0]         idx_q, idx_d;
    logic [31:0]        cause_q, cause_d;
    logic [DEPTH_W-1:0] depth_q, depth_d;

    logic [N_IRQ-1:0]   masked;
    logic               sel_vld;
    logic [3:0]         sel_idx;

    // mie bits outside the implemented line range carry no meaning here.
    logic               unused_mie;
    assign unused_mie = ^mie_i;

    assign masked = irq_req_i & mie_i[IRQ_MIE_OFFSET +: N_IRQ];

    irq_priority_enc #(
        .N (N_IRQ)
    ) u_prio (
        .req_i (masked),
        .vld_o (sel_vld),
        .idx_o (sel_idx)
    );

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cause_d   = cause_q;
        depth_d   = depth_q;
        irq_o     = 1'b0;
        irq_ret_o = '0;

        case (state_q)
            IDLE: begin
                cause_d = '0;
                // A synchronous exception in the same cycle takes the trap instead;
                // the level request is simply seen again next cycle.
                if (sel_vld && !exception_i) begin
                    irq_o   = 1'b1;
                    idx_d   = sel_idx;
                    cause_d = IRQ_CAUSE_BASE + 32'(sel_idx);
                    state_d = BUSY;
                end
            end

            BUSY: begin
                // depth tracks exceptions nested inside the handler so that only the
                // handler's own mret releases the line. exception+mret together cancel.
                if (exception_i && !mret_i) begin
                    if (depth_q != DEPTH_MAX) begin
                        depth_d = depth_q + 1'b1;
                    end
                end else if (mret_i && !exception_i) begin
                    if (depth_q != '0) begin
                        depth_d = depth_q - 1'b1;
                    end else begin
                        state_d = RETURN;
                    end
                end
            end

            RETURN: begin
                for (int k = 0; k < N_IRQ; k++) begin
                    irq_ret_o[k] = (idx_q == 4'(k));
                end
                depth_d = '0;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // The cause must be valid in the issue cycle for the trap path, so IDLE shows
    // the value being latched; afterwards the latched copy is held.
    assign irq_cause_o = (state_q == IDLE) ? cause_d : cause_q;
    assign busy_o      = (state_q != IDLE);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            idx_q   <= 4'd0;
            cause_q <= 32'h0;
            depth_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cause_q <= cause_d;
            depth_q <= depth_d;
        end
    end

endmodule

// File: tb/tb_irq_controller.sv
// Directed-vector bench for irq_controller with hand-computed expectations.
// Inputs change 1ns after the rising edge; outputs are sampled 1ns later.
// Summary counts every vector compared and every miscompare.
module tb_irq_controller;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [15:0] irq_req_i;
    logic [31:0] mie_i;
    logic        exception_i;
    logic        mret_i;
    logic        irq_o;
    logic [31:0] irq_cause_o;
    logic [15:0] irq_ret_o;
    logic        busy_o;

    int n_vec = 0;
    int n_err = 0;

    always #10 clk_i = ~clk_i;

    irq_controller #(
        .N_IRQ   (16),
        .DEPTH_W (2)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .irq_req_i   (irq_req_i),
        .mie_i       (mie_i),
        .exception_i (exception_i),
        .mret_i      (mret_i),
        .irq_o       (irq_o),
        .irq_cause_o (irq_cause_o),
        .irq_ret_o   (irq_ret_o),
        .busy_o      (busy_o)
    );

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance to 1ns past the next rising edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        logic seen;

        rst_i = 1'b1; irq_req_i = '0; mie_i = '0; exception_i = 1'b0; mret_i = 1'b0;
        tick(); tick();
        rst_i = 1'b0;
        #1;
        check_vec("rst_irq",   {31'd0, irq_o},  32'd0);
        check_vec("rst_busy",  {31'd0, busy_o}, 32'd0);
        check_vec("rst_cause", irq_cause_o,     32'h0);
        check_vec("rst_ret",   {16'd0, irq_ret_o}, 32'd0);

        // Lines 2 and 5 enabled and requesting: line 2 wins.
        irq_req_i = 16'h0024; mie_i = 32'h0024_0000;
        #1;
        check_vec("t2_irq",   {31'd0, irq_o}, 32'd1);
        check_vec("t2_cause", irq_cause_o,    32'h8000_0012);
        tick();
        check_vec("t2_pulse", {31'd0, irq_o},  32'd0);
        check_vec("t2_busy",  {31'd0, busy_o}, 32'd1);
        check_vec("t2_hold",  irq_cause_o,     32'h8000_0012);
        tick(); tick(); tick(); tick();
        mret_i = 1'b1;
        tick();
        mret_i = 1'b0;
        #1;
        check_vec("t2_ret",      {16'd0, irq_ret_o}, 32'h0000_0004);
        check_vec("t2_ret_busy", {31'd0, busy_o},    32'd1);
        check_vec("t2_ret_noiq", {31'd0, irq_o},     32'd0);
        check_vec("t2_ret_cause", irq_cause_o,       32'h8000_0012);
        irq_req_i = 16'h0000;
        tick();
        check_vec("t2_idle_busy", {31'd0, busy_o},    32'd0);
        check_vec("t2_idle_ret",  {16'd0, irq_ret_o}, 32'd0);

        // Masked request never issues; enabling mie issues immediately.
        irq_req_i = 16'h0001; mie_i = 32'h0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (irq_o || busy_o) seen = 1'b1;
            tick();
        end
        check_vec("t3_masked", {31'd0, seen}, 32'd0);
        mie_i = 32'h0001_0000;
        #1;
        check_vec("t3_irq",   {31'd0, irq_o}, 32'd1);
        check_vec("t3_cause", irq_cause_o,    32'h8000_0010);
        tick();
        // mie change while busy does not disturb the latched line.
        mie_i = 32'h0;
        mret_i = 1'b1;
        tick();
        mret_i = 1'b0;
        #1;
        check_vec("t3_ret", {16'd0, irq_ret_o}, 32'h0000_0001);
        irq_req_i = 16'h0000;
        tick();

        // Exception in the same cycle blocks issue; next cycle it goes.
        irq_req_i = 16'h0001; mie_i = 32'h0001_0000; exception_i = 1'b1;
        #1;
        check_vec("t4_exc_irq", {31'd0, irq_o}, 32'd0);
        tick();
        check_vec("t4_exc_busy", {31'd0, busy_o}, 32'd0);
        exception_i = 1'b0;
        #1;
        check_vec("t4_irq", {31'd0, irq_o}, 32'd1);
        tick();
        // exception and mret together leave depth at 0 and stay BUSY.
        exception_i = 1'b1; mret_i = 1'b1;
        tick();
        exception_i = 1'b0;
        check_vec("t4_both_busy", {31'd0, busy_o},    32'd1);
        check_vec("t4_both_ret",  {16'd0, irq_ret_o}, 32'd0);
        tick();
        mret_i = 1'b0;
        #1;
        check_vec("t4_ret", {16'd0, irq_ret_o}, 32'h0000_0001);
        irq_req_i = 16'h0000;
        tick();

        // Line 7 in service, two nested exceptions, three mrets; line 1 waits.
        irq_req_i = 16'h0080; mie_i = 32'h0082_0000;
        #1;
        check_vec("t5_irq",   {31'd0, irq_o}, 32'd1);
        check_vec("t5_cause", irq_cause_o,    32'h8000_0017);
        tick();
        irq_req_i = 16'h0082; exception_i = 1'b1;
        #1;
        check_vec("t5_noissue", {31'd0, irq_o}, 32'd0);
        tick(); tick();
        exception_i = 1'b0; mret_i = 1'b1;
        tick();
        check_vec("t5_m1_ret",  {16'd0, irq_ret_o}, 32'd0);
        check_vec("t5_m1_busy", {31'd0, busy_o},    32'd1);
        tick();
        check_vec("t5_m2_ret",  {16'd0, irq_ret_o}, 32'd0);
        check_vec("t5_m2_busy", {31'd0, busy_o},    32'd1);
        tick();
        mret_i = 1'b0;
        #1;
        check_vec("t5_m3_ret",  {16'd0, irq_ret_o}, 32'h0000_0080);
        check_vec("t5_ret_irq", {31'd0, irq_o},     32'd0);
        irq_req_i = 16'h0002;
        tick();
        check_vec("t5_l1_irq",   {31'd0, irq_o}, 32'd1);
        check_vec("t5_l1_cause", irq_cause_o,    32'h8000_0011);
        tick();
        mret_i = 1'b1;
        tick();
        mret_i = 1'b0;
        #1;
        check_vec("t5_l1_ret", {16'd0, irq_ret_o}, 32'h0000_0002);
        irq_req_i = 16'h0000;
        tick();

        // Reset in the middle of servicing line 3.
        irq_req_i = 16'h0008; mie_i = 32'h0008_0000;
        #1;
        check_vec("t6_irq", {31'd0, irq_o}, 32'd1);
        tick();
        check_vec("t6_busy", {31'd0, busy_o}, 32'd1);
        rst_i = 1'b1; irq_req_i = 16'h0000;
        tick();
        rst_i = 1'b0;
        #1;
        check_vec("t6_rst_busy",  {31'd0, busy_o},    32'd0);
        check_vec("t6_rst_irq",   {31'd0, irq_o},     32'd0);
        check_vec("t6_rst_cause", irq_cause_o,        32'h0);
        check_vec("t6_rst_ret",   {16'd0, irq_ret_o}, 32'd0);
        mret_i = 1'b1;
        tick();
        mret_i = 1'b0;
        #1;
        check_vec("t6_mret_ret",  {16'd0, irq_ret_o}, 32'd0);
        tick();
        check_vec("t6_mret_ret2", {16'd0, irq_ret_o}, 32'd0);

        // mret in IDLE with nothing pending.
        mret_i = 1'b1;
        tick();
        mret_i = 1'b0;
        #1;
        check_vec("t7_ret",  {16'd0, irq_ret_o}, 32'd0);
        check_vec("t7_busy", {31'd0, busy_o},    32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
